// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction fetch unit.
//   - FETCH_ROM_SIZE / FETCH_INSTR_WIDTH : default memory depth and word width
//   - fetch_state_e                      : fetch controller states
//   - pc_sel_e                           : next-PC source selector used between
//                                          fetch_unit and pc_next
//   - fetch_addr_width()                 : address width for a given depth
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned FETCH_ROM_SIZE    = 256;
  localparam int unsigned FETCH_INSTR_WIDTH = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Source of the next PC value.
  typedef enum logic [2:0] {
    PC_HOLD  = 3'd0,  // keep current PC
    PC_SEQ   = 3'd1,  // PC + 1, wrapping at the end of memory
    PC_ABS   = 3'd2,  // absolute redirect target
    PC_REL   = 3'd3,  // pc_out + signed offset
    PC_START = 3'd4   // restart address
  } pc_sel_e;

  // Address width for a memory of 'depth' words; never narrower than one bit
  // so a single-word memory still gets a legal vector.
  function automatic int unsigned fetch_addr_width(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : fetch_pkg

// File: rtl/pc_next.sv
// -----------------------------------------------------------------------------
// pc_next
//   Purely combinational next-PC selection for the fetch unit. All results are
//   reduced modulo ROM_SIZE so the PC never leaves the instruction memory.
//
//   Parameters
//     ROM_SIZE : instruction memory depth in words
//     AW       : address width (must be fetch_addr_width(ROM_SIZE))
//   Ports
//     sel_i        in  pc_sel_e  which source to use
//     pc_i         in  AW        current PC register
//     base_i       in  AW        address of the instruction now in decode
//                                (base for relative targets)
//     tgt_i        in  AW        absolute target or signed offset
//     start_addr_i in  AW        restart address
//     npc_o        out AW        next PC value
// -----------------------------------------------------------------------------
module pc_next
  import fetch_pkg::*;
#(
  parameter int unsigned ROM_SIZE = FETCH_ROM_SIZE,
  parameter int unsigned AW       = fetch_addr_width(FETCH_ROM_SIZE)
) (
  input  pc_sel_e         sel_i,
  input  logic [AW-1:0]   pc_i,
  input  logic [AW-1:0]   base_i,
  input  logic [AW-1:0]   tgt_i,
  input  logic [AW-1:0]   start_addr_i,
  output logic [AW-1:0]   npc_o
);

  // Two guard bits: one for the sign of the offset, one for the carry out of
  // base + offset.
  localparam int unsigned        EW        = AW + 2;
  localparam logic [EW-1:0]      SIZE_U    = EW'(ROM_SIZE);
  localparam logic signed [EW-1:0] SIZE_S  = EW'(ROM_SIZE);
  localparam logic [AW-1:0]      LAST_ADDR = AW'(ROM_SIZE - 1);

  logic [AW-1:0]        seq_addr;
  logic [AW-1:0]        abs_addr;
  logic [AW-1:0]        rel_addr;
  logic [EW-1:0]        tgt_ext;
  logic signed [EW-1:0] rel_sum;
  logic signed [EW-1:0] rel_fix;

  // Explicit wrap compare keeps non-power-of-two depths correct.
  assign seq_addr = (pc_i == LAST_ADDR) ? '0 : pc_i + AW'(1);

  // An absolute target can only exceed the depth by less than one memory's
  // worth (tgt < 2^AW <= 2*ROM_SIZE), so one subtraction reduces it.
  assign tgt_ext  = {2'b00, tgt_i};
  assign abs_addr = (tgt_ext >= SIZE_U) ? AW'(tgt_ext - SIZE_U) : tgt_i;

  // base in [0, ROM_SIZE) and |offset| <= 2^(AW-1) <= ROM_SIZE, so the sum is
  // at most one memory size outside the legal range in either direction.
  assign rel_sum = $signed({2'b00, base_i}) + $signed({{2{tgt_i[AW-1]}}, tgt_i});

  always_comb begin
    rel_fix = rel_sum;
    if (rel_sum[EW-1]) begin
      rel_fix = rel_sum + SIZE_S;
    end else if (rel_sum >= SIZE_S) begin
      rel_fix = rel_sum - SIZE_S;
    end
  end

  assign rel_addr = rel_fix[AW-1:0];

  always_comb begin
    npc_o = pc_i;
    unique case (sel_i)
      PC_HOLD:  npc_o = pc_i;
      PC_SEQ:   npc_o = seq_addr;
      PC_ABS:   npc_o = abs_addr;
      PC_REL:   npc_o = rel_addr;
      PC_START: npc_o = start_addr_i;
      default:  npc_o = pc_i;
    endcase
  end

endmodule : pc_next

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Single-issue instruction fetch stage. The PC register addresses an
//   external instruction memory with combinational read; the returned word is
//   captured one cycle later into instr_out together with its address.
//
//   Parameters
//     ROM_SIZE    : instruction memory depth in words
//     INSTR_WIDTH : instruction width in bits
//     START_ADDR  : first fetch address after start
//   Ports
//     clk          in   1   rising-edge clock
//     rst_n        in   1   asynchronous active-low reset
//     start        in   1   begin / restart fetching at START_ADDR
//     stall        in   1   hold PC and output register
//     redirect     in   1   taken branch or jump from decode
//     redirect_rel in   1   1 = relative target, 0 = absolute
//     redirect_tgt in   AW  absolute address or signed offset from pc_out
//     halt         in   1   stop fetching
//     instr_addr   out  AW  address to instruction memory (PC register)
//     instr_in     in   IW  read data from instruction memory
//     instr_out    out  IW  registered instruction to decode
//     pc_out       out  AW  address of instr_out
//     instr_valid  out  1   instr_out holds a live instruction
//     done         out  1   high while halted
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter  int unsigned ROM_SIZE    = FETCH_ROM_SIZE,
  parameter  int unsigned INSTR_WIDTH = FETCH_INSTR_WIDTH,
  parameter  int unsigned START_ADDR  = 0,
  localparam int unsigned AW          = fetch_addr_width(ROM_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic                   redirect_rel,
  input  logic [AW-1:0]          redirect_tgt,
  input  logic                   halt,
  output logic [AW-1:0]          instr_addr,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [AW-1:0]          pc_out,
  output logic                   instr_valid,
  output logic                   done
);

  localparam logic [AW-1:0] START_PC = AW'(START_ADDR);

  fetch_state_e           state_q, state_d;
  logic [AW-1:0]          pc_q, pc_d;
  logic [AW-1:0]          pc_out_q, pc_out_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  pc_sel_e                pc_sel;

  // ---------------------------------------------------------------------------
  // Next-PC datapath
  // ---------------------------------------------------------------------------
  pc_next #(
    .ROM_SIZE (ROM_SIZE),
    .AW       (AW)
  ) u_pc_next (
    .sel_i        (pc_sel),
    .pc_i         (pc_q),
    .base_i       (pc_out_q),
    .tgt_i        (redirect_tgt),
    .start_addr_i (START_PC),
    .npc_o        (pc_d)
  );

  // ---------------------------------------------------------------------------
  // Controller: next state, PC source and output-register updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    pc_sel   = PC_HOLD;

    unique case (state_q)
      IDLE: begin
        // PC is pinned to the start address so the first fetch after start
        // already presents START_ADDR on instr_addr.
        valid_d = 1'b0;
        pc_sel  = PC_START;
        if (start) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (halt) begin
          state_d = HALT;
          valid_d = 1'b0;
        end else if (redirect) begin
          // The word fetched this cycle is on the wrong path: drop it by
          // clearing valid and refetch from the target.
          pc_sel  = redirect_rel ? PC_REL : PC_ABS;
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d  = instr_in;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_sel   = PC_SEQ;
        end
      end

      HALT: begin
        valid_d = 1'b0;
        if (start) begin
          state_d = RUN;
          pc_sel  = PC_START;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        pc_sel  = PC_START;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= START_PC;
      pc_out_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign instr_addr  = pc_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  assign done        = (state_q == HALT);

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A behavioural model steps once per
//   clock edge and queues the (instruction, address) pair decode should see;
//   an independent monitor pops and compares whenever instr_valid is high.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int ROM_SIZE = 256;
  localparam int IW       = 9;
  localparam int AW       = 8;
  localparam int START    = 0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic          redirect_rel = 1'b0;
  logic [AW-1:0] redirect_tgt = '0;
  logic          halt = 1'b0;
  logic [AW-1:0] instr_addr;
  logic [IW-1:0] instr_in;
  logic [IW-1:0] instr_out;
  logic [AW-1:0] pc_out;
  logic          instr_valid;
  logic          done;

  logic [IW-1:0] rom [ROM_SIZE];

  fetch_unit #(
    .ROM_SIZE    (ROM_SIZE),
    .INSTR_WIDTH (IW),
    .START_ADDR  (START)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_rel (redirect_rel),
    .redirect_tgt (redirect_tgt),
    .halt         (halt),
    .instr_addr   (instr_addr),
    .instr_in     (instr_in),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .instr_valid  (instr_valid),
    .done         (done)
  );

  assign instr_in = rom[instr_addr];

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: mode 0 = idle, 1 = running, 2 = halted
  // ---------------------------------------------------------------------------
  typedef struct {
    int instr;
    int pc;
  } exp_t;

  exp_t exp_q[$];
  int   m_mode  = 0;
  int   m_pc    = START;
  int   m_pcout = 0;
  int   m_instr = 0;
  bit   m_valid = 1'b0;

  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = START;
    m_pcout = 0;
    m_instr = 0;
    m_valid = 1'b0;
    exp_q.delete();
  endtask

  // One clock edge of behaviour, from the rules: halt beats redirect beats
  // stall beats sequential fetch; only start matters outside of running.
  task automatic model_edge(input bit s, input bit st, input bit rd, input bit rl,
                            input int tgt, input bit h);
    int off;
    if (m_mode == 0 || m_mode == 2) begin
      m_valid = 1'b0;
      if (s) begin
        m_mode = 1;
        m_pc   = START;
      end
    end else begin
      if (h) begin
        m_mode  = 2;
        m_valid = 1'b0;
      end else if (rd) begin
        if (rl) begin
          off  = (tgt >= ROM_SIZE / 2) ? tgt - ROM_SIZE : tgt;
          m_pc = ((m_pcout + off) % ROM_SIZE + ROM_SIZE) % ROM_SIZE;
        end else begin
          m_pc = tgt % ROM_SIZE;
        end
        m_valid = 1'b0;
      end else if (!st) begin
        m_instr = int'(rom[m_pc]);
        m_pcout = m_pc;
        m_valid = 1'b1;
        m_pc    = (m_pc + 1) % ROM_SIZE;
      end
    end
    if (m_valid) begin
      exp_q.push_back('{m_instr, m_pcout});
    end
  endtask

  task automatic step(input bit s, input bit st, input bit rd, input bit rl,
                      input logic [AW-1:0] tgt, input bit h);
    @(negedge clk);
    start        = s;
    stall        = st;
    redirect     = rd;
    redirect_rel = rl;
    redirect_tgt = tgt;
    halt         = h;
    @(posedge clk);
    model_edge(s, st, rd, rl, int'(tgt), h);
  endtask

  // Reset pulse landing between clock edges; outputs must clear at once.
  task automatic async_reset();
    #3;
    start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_rel = 1'b0; halt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr_out), 32'd0);
    chk("rst_pc_out", 32'(pc_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(instr_addr), 32'(START));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && rst_n) begin
        chk("valid", 32'(instr_valid), 32'(m_valid));
        chk("done", 32'(done), 32'(m_mode == 2));
        chk("instr_addr", 32'(instr_addr), 32'(m_pc));
        if (instr_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_empty: got pc_out %0d with nothing expected at %0t", pc_out, $time);
          end else begin
            e = exp_q.pop_front();
            chk("instr_out", 32'(instr_out), 32'(e.instr));
            chk("pc_out", 32'(pc_out), 32'(e.pc));
            $display("txn pc_out=%0d instr_out=%0d exp_pc=%0d exp_instr=%0d",
                     pc_out, instr_out, e.pc, e.instr);
          end
        end else if (exp_q.size() > 0) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    for (int k = 0; k < ROM_SIZE; k++) rom[k] = IW'(k);

    #1 rst_n = 1'b0;
    #10;
    chk("init_valid", 32'(instr_valid), 32'd0);
    chk("init_instr", 32'(instr_out), 32'd0);
    chk("init_pc_out", 32'(pc_out), 32'd0);
    chk("init_done", 32'(done), 32'd0);
    chk("init_addr", 32'(instr_addr), 32'(START));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;

    // Idle ignores everything except start
    step(0, 1, 1, 0, 8'd9, 1);
    step(0, 0, 0, 0, 8'd0, 0);

    // Sequential fetch, then a 3-cycle stall with PC = 5
    step(1, 0, 0, 0, 8'd0, 0);
    repeat (5) step(0, 0, 0, 0, 8'd0, 0);
    repeat (3) step(0, 1, 0, 0, 8'd0, 0);
    #1 chk("stall_hold_pc", 32'(pc_out), 32'd4);
    repeat (3) step(0, 0, 0, 0, 8'd0, 0);
    step(1, 0, 0, 0, 8'd0, 0);  // start while running is just a normal cycle

    // Absolute redirect to the last word at pc_out = 3, wrap afterwards
    step(0, 0, 0, 0, 8'd0, 1);
    step(1, 0, 0, 0, 8'd0, 0);
    repeat (4) step(0, 0, 0, 0, 8'd0, 0);
    step(0, 0, 1, 0, 8'hFF, 0);
    #1 chk("abs_bubble", 32'(instr_valid), 32'd0);
    repeat (3) step(0, 0, 0, 0, 8'd0, 0);
    #1 chk("abs_wrap_pc", 32'(pc_out), 32'd1);

    // Relative redirect -2 from pc_out = 10, together with stall
    step(0, 0, 0, 0, 8'd0, 1);
    step(1, 0, 0, 0, 8'd0, 0);
    repeat (11) step(0, 0, 0, 0, 8'd0, 0);
    step(0, 1, 1, 1, 8'hFE, 0);
    repeat (2) step(0, 0, 0, 0, 8'd0, 0);
    #1 chk("rel_pc", 32'(pc_out), 32'd9);

    // Halt with simultaneous redirect at pc_out = 7, then restart
    step(0, 0, 0, 0, 8'd0, 1);
    step(1, 0, 0, 0, 8'd0, 0);
    repeat (8) step(0, 0, 0, 0, 8'd0, 0);
    step(0, 0, 1, 0, 8'd50, 1);
    #1 chk("halt_done", 32'(done), 32'd1);
    step(0, 1, 1, 1, 8'd3, 1);
    step(1, 0, 0, 0, 8'd0, 0);
    #1 chk("restart_done", 32'(done), 32'd0);
    step(0, 0, 0, 0, 8'd0, 0);
    #1 chk("restart_pc", 32'(pc_out), 32'(START));

    // Reset pulse mid-run; a new start is needed afterwards
    repeat (3) step(0, 0, 0, 0, 8'd0, 0);
    async_reset();
    step(0, 0, 0, 0, 8'd0, 0);
    #1 chk("post_rst_idle", 32'(instr_valid), 32'd0);

    // Randomised phase with random memory contents
    for (int k = 0; k < ROM_SIZE; k++) rom[k] = IW'($urandom_range(0, (1 << IW) - 1));
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 15) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 1) == 1,
           AW'($urandom_range(0, ROM_SIZE - 1)),
           $urandom_range(0, 39) == 0);
      if ($urandom_range(0, 399) == 0) async_reset();
    end

    step(0, 0, 0, 0, 8'd0, 0);
    #2;
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_fetch_unit
